// File: rtl/icache_line_fill.sv
// icache_line_fill
//   Direct-mapped, read-only instruction cache that sits between fetch and imem.
//   Each line holds 512 bits (16 words).
//   A lookup that hits returns the instruction in the same cycle.
//   A miss stalls fetch, latches the miss address and requests the whole line
//   from imem. When imem's one-cycle READY pulse arrives, the line is written
//   and the lookup is retried on the following cycle.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   pc         : fetch address; bits [1:0] are ignored
//   instr      : instruction at pc; valid while stallF = 0
//   stallF     : fetch stall; high on a miss and while a fill is pending
//   hit        : lookup hit to imem; only ever high in LOOKUP
//   mem_a      : line-aligned fill address to imem
//   mem_ready  : imem READY pulse; mem_rd carries the line on that cycle
//   mem_rd     : 512-bit line; word k sits at bits [32k+31:32k]
//   hit_count  : number of LOOKUP cycles that hit (wraps)
//   miss_count : number of misses (wraps)
module icache_line_fill #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc,
  output logic [31:0]  instr,
  output logic         stallF,
  output logic         hit,
  output logic [31:0]  mem_a,
  input  logic         mem_ready,
  input  logic [511:0] mem_rd,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int TAG_W = 32 - 6 - IDX_W;

  typedef enum logic {
    S_LOOKUP = 1'b0,
    S_WAIT   = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [511:0]         r_data [NUM_LINES];
  logic [31:0]          r_miss_addr;
  logic [31:0]          r_hit_count;
  logic [31:0]          r_miss_count;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [3:0]           w_off;
  logic [IDX_W-1:0]     w_fill_idx;
  logic [TAG_W-1:0]     w_fill_tag;
  logic                 w_lookup_hit;
  logic                 w_fill;
  logic [511:0]         w_line;
  logic                 w_unused_pc_lsbs;

  assign w_idx      = pc[6+IDX_W-1:6];
  assign w_tag      = pc[31:6+IDX_W];
  assign w_off      = pc[5:2];
  assign w_fill_idx = r_miss_addr[6+IDX_W-1:6];
  assign w_fill_tag = r_miss_addr[31:6+IDX_W];
  assign w_line     = r_data[w_idx];

  // Word-aligned fetch: the byte offset inside a word carries no information.
  assign w_unused_pc_lsbs = &{1'b0, pc[1:0]};

  // Qualified by state so that hit can never rise during WAIT;
  // imem would otherwise restart its delay counter mid-fill.
  assign w_lookup_hit = (r_state == S_LOOKUP) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A READY pulse seen while in LOOKUP is deliberately ignored.
  assign w_fill = (r_state == S_WAIT) && mem_ready;

  always_comb begin
    w_state_next = r_state;
    hit          = 1'b0;
    stallF       = 1'b1;
    instr        = 32'h0;
    mem_a        = {pc[31:6], 6'b0};
    case (r_state)
      S_LOOKUP: begin
        hit = w_lookup_hit;
        if (w_lookup_hit) begin
          stallF = 1'b0;
          instr  = w_line[{w_off, 5'b0} +: 32];
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Hold the latched miss address even if fetch redirects pc.
        mem_a = {r_miss_addr[31:6], 6'b0};
        if (mem_ready) begin
          w_state_next = S_LOOKUP;
        end
      end
      default: w_state_next = S_LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOOKUP;
      r_valid      <= '0;
      r_miss_addr  <= 32'h0;
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_lookup_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (r_state == S_LOOKUP && !w_lookup_hit) begin
        r_miss_addr  <= pc;
        r_miss_count <= r_miss_count + 32'd1;
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset, so they can map onto RAM.
  // While rst is low the state sits in LOOKUP, so w_fill stays low.
  // An interrupted fill therefore never writes its line.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_rd;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_line_fill.sv
// tb_icache_line_fill
//   Directed test of icache_line_fill. Expected values are hand-computed.
//   Scenarios covered:
//     - cold miss and fill
//     - hit on another word of the same line
//     - stray READY pulse
//     - conflict eviction
//     - redirect during WAIT
//     - reset during WAIT
//   Fill lines are built so that word k = base + (k << 8).
module tb_icache_line_fill;

  logic         clk;
  logic         rst;
  logic [31:0]  pc;
  logic [31:0]  instr;
  logic         stallF;
  logic         hit;
  logic [31:0]  mem_a;
  logic         mem_ready;
  logic [511:0] mem_rd;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks;
  int n_fail;

  icache_line_fill #(.NUM_LINES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr      (instr),
    .stallF     (stallF),
    .hit        (hit),
    .mem_a      (mem_a),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) begin
      l[32*k +: 32] = base + (32'(k) << 8);
    end
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one clock edge, then step off it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one line on mem_rd with a single-cycle READY pulse.
  task automatic fill(input logic [31:0] base);
    mem_ready = 1'b1;
    mem_rd    = make_line(base);
    tick();
    mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    pc        = 32'h0;
    mem_ready = 1'b0;
    mem_rd    = '0;

    // Reset state
    repeat (2) tick();
    #1;
    check("rst_stall", {31'b0, stallF}, 32'd1);
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_hitcnt", hit_count, 32'h0);
    check("rst_misscnt", miss_count, 32'h0);

    // Cold miss on 0x0
    rst = 1'b1;
    #1;
    check("cold_stall", {31'b0, stallF}, 32'd1);
    check("cold_hit", {31'b0, hit}, 32'd0);
    tick();
    check("cold_misscnt", miss_count, 32'd1);
    check("cold_wait_mem_a", mem_a, 32'h0);
    repeat (3) tick();
    check("wait_hit_low", {31'b0, hit}, 32'd0);
    check("wait_misscnt", miss_count, 32'd1);
    fill(32'h20080005);
    check("fill0_stall", {31'b0, stallF}, 32'd0);
    check("fill0_hit", {31'b0, hit}, 32'd1);
    check("fill0_instr", instr, 32'h20080005);
    check("fill0_hitcnt_before", hit_count, 32'd0);
    tick();
    check("fill0_hitcnt_after", hit_count, 32'd1);

    // Word 15 of the same line hits immediately
    pc = 32'h3C;
    #1;
    check("w15_instr", instr, 32'h20080F05);
    check("w15_hit", {31'b0, hit}, 32'd1);
    check("w15_misscnt", miss_count, 32'd1);

    // Stray READY while hitting in LOOKUP
    fill(32'hDEAD0000);
    check("stray_instr", instr, 32'h20080F05);
    check("stray_hit", {31'b0, hit}, 32'd1);
    check("stray_hitcnt", hit_count, 32'd2);
    pc = 32'h0;
    #1;
    check("stray_w0", instr, 32'h20080005);

    // Conflict: 0x200 maps to index 0 with a different tag
    pc = 32'h200;
    #1;
    check("conf_hit", {31'b0, hit}, 32'd0);
    check("conf_mem_a", mem_a, 32'h200);
    tick();
    check("conf_misscnt", miss_count, 32'd2);
    check("conf_wait_mem_a", mem_a, 32'h200);
    fill(32'h11110000);
    check("conf_instr", instr, 32'h11110000);
    pc = 32'h0;
    #1;
    check("evict_hit", {31'b0, hit}, 32'd0);
    check("evict_stall", {31'b0, stallF}, 32'd1);
    tick();
    check("evict_misscnt", miss_count, 32'd3);
    fill(32'h20080005);
    check("refill_instr", instr, 32'h20080005);

    // Redirect during WAIT
    pc = 32'h40;
    #1;
    check("redir_hit", {31'b0, hit}, 32'd0);
    tick();
    pc = 32'h80;
    #1;
    repeat (2) tick();
    check("redir_mem_a_held", mem_a, 32'h40);
    check("redir_hit_wait", {31'b0, hit}, 32'd0);
    check("redir_misscnt", miss_count, 32'd4);
    fill(32'h44440000);
    check("redir_retry_hit", {31'b0, hit}, 32'd0);
    check("redir_retry_mem_a", mem_a, 32'h80);
    tick();
    check("redir_misscnt2", miss_count, 32'd5);
    fill(32'h88880000);
    check("redir_80_instr", instr, 32'h88880000);
    pc = 32'h44;
    #1;
    check("redir_40_hit", {31'b0, hit}, 32'd1);
    check("redir_40_instr", instr, 32'h44440100);

    // Reset during WAIT, with a READY pulse inside the reset cycle
    pc = 32'hC0;
    #1;
    tick();
    tick();
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rd    = make_line(32'hCCCC0000);
    #1;
    check("wrst_hitcnt", hit_count, 32'd0);
    check("wrst_misscnt", miss_count, 32'd0);
    check("wrst_stall", {31'b0, stallF}, 32'd1);
    check("wrst_mem_a", mem_a, 32'hC0);
    check("wrst_instr", instr, 32'h0);
    tick();
    rst       = 1'b1;
    mem_ready = 1'b0;
    pc        = 32'h80;
    #1;
    check("wrst_valid_cleared", {31'b0, hit}, 32'd0);
    tick();
    check("wrst_misscnt2", miss_count, 32'd1);
    check("wrst_mem_a2", mem_a, 32'h80);
    fill(32'h88880000);
    check("wrst_refill_instr", instr, 32'h88880000);
    pc = 32'hC0;
    #1;
    check("wrst_no_write", {31'b0, hit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
